dma_io_responder: RTL and testbench

DMA_IO_RESPONDER -- requirements
Module: dma_io_responder

---
 rtl/dma_io_responder_if.sv | 24 ++
 rtl/dma_io_responder.sv | 131 +++++++++++++
 tb/tb_dma_io_responder.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_io_responder_if.sv
// Bus between an 8237-style DMA controller and the I/O responder:
// request/acknowledge handshake, read/write strobes, end-of-process and the data bus.
interface dma_io_responder_if #(
    parameter int DW = 8
);
    logic          DREQ;
    logic          DACK_N;
    logic          IOR_N;
    logic          IOW_N;
    logic          EOP_N;
    logic [DW-1:0] db_in;
    logic [DW-1:0] db_out;
    logic          db_oe;

    modport master (
        input  DREQ, db_out, db_oe,
        output DACK_N, IOR_N, IOW_N, EOP_N, db_in
    );

    modport slave (
        output DREQ, db_out, db_oe,
        input  DACK_N, IOR_N, IOW_N, EOP_N, db_in
    );
endinterface

// File: rtl/dma_io_responder.sv
// Single-transfer DMA I/O responder: a local FIFO drained (dir=0) or filled (dir=1)
// one beat at a time by an external DMA controller.
//
// state | meaning
// IDLE  | waiting for enable, no terminal count, and FIFO ready for the selected direction
// REQ   | DREQ asserted, waiting for DACK_N
// ACK   | acknowledged, waiting for the direction's strobe (DACK_N release aborts)
// XFER  | strobe active; beat completes on the first cycle the strobe is seen high
// TCW   | terminal count reached, holding off requests until tc_clr
module dma_io_responder #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    dma_io_responder_if.slave bus,
    input  logic          en,
    input  logic          dir,
    input  logic          tc_clr,
    input  logic          loc_wr,
    input  logic [DW-1:0] loc_wdata,
    input  logic          loc_rd,
    output logic [DW-1:0] loc_rdata,
    output logic          full,
    output logic          empty,
    output logic          xfer_pulse,
    output logic          tc
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        ACK  = 5'b00100,
        XFER = 5'b01000,
        TCW  = 5'b10000
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] head;
    logic [DW-1:0] wdata_q;
    logic          eop_q;

    logic          strobe_n;
    logic          ready;
    logic          in_beat;
    logic          eop_any;
    logic          done;
    logic          bus_push;
    logic          bus_pop;
    logic          do_push;
    logic          do_pop;
    logic [DW-1:0] push_data;
    logic          capture;

    assign strobe_n = dir ? bus.IOW_N : bus.IOR_N;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready    = dir ? !full : !empty;
    assign in_beat  = (state == ACK) || (state == XFER);
    assign eop_any  = eop_q || (in_beat && !bus.EOP_N);
    assign done     = (state == XFER) && strobe_n;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (en && !tc && ready) state_nxt = REQ;
            REQ: begin
                if (!bus.DACK_N)          state_nxt = ACK;
                else if (!en || !ready)   state_nxt = IDLE;
            end
            ACK: begin
                if (bus.DACK_N)           state_nxt = eop_any ? TCW : IDLE;
                else if (!strobe_n)       state_nxt = XFER;
            end
            XFER: if (strobe_n) state_nxt = eop_any ? TCW : IDLE;
            TCW:  if (tc_clr)   state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    assign bus.DREQ   = (state == REQ);
    assign bus.db_oe  = (state == XFER) && !dir && !bus.IOR_N && !bus.DACK_N;
    assign bus.db_out = bus.db_oe ? head : '0;
    assign loc_rdata  = empty ? '0 : head;

    // A bus beat owns its end of the FIFO for that cycle; a local op on the same end is dropped.
    assign bus_push  = done && dir;
    assign bus_pop   = done && !dir;
    assign do_push   = !full && (bus_push || loc_wr);
    assign do_pop    = !empty && (bus_pop || loc_rd);
    assign push_data = bus_push ? wdata_q : loc_wdata;

    // Write data is held from the last strobe-low cycle, including the ACK cycle that saw it.
    assign capture = dir && !bus.IOW_N && (((state == ACK) && !bus.DACK_N) || (state == XFER));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wdata_q    <= '0;
            eop_q      <= 1'b0;
            xfer_pulse <= 1'b0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            xfer_pulse <= done;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (capture) wdata_q <= bus.db_in;
            eop_q <= ((state_nxt == ACK) || (state_nxt == XFER)) ? eop_any : 1'b0;
            if ((state_nxt == TCW) && (state != TCW))
                tc <= 1'b1;
            else if ((state == TCW) && tc_clr)
                tc <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_dma_io_responder.sv
// Self-checking bench for dma_io_responder: directed scenarios plus a randomized
// controller, all compared every cycle against a queue-based behavioural model.
module tb_dma_io_responder;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    localparam int P_WAIT   = 0;
    localparam int P_REQ    = 1;
    localparam int P_GRANT  = 2;
    localparam int P_STROBE = 3;
    localparam int P_HALT   = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          en = 1'b0, dir = 1'b0, tc_clr = 1'b0;
    logic          loc_wr = 1'b0, loc_rd = 1'b0;
    logic [DW-1:0] loc_wdata = '0;
    logic [DW-1:0] loc_rdata;
    logic          full, empty, xfer_pulse, tc;
    bit            rand_loc = 1'b0;

    int checks = 0;
    int errors = 0;

    dma_io_responder_if #(.DW(DW)) bus ();

    dma_io_responder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus),
        .en(en), .dir(dir), .tc_clr(tc_clr),
        .loc_wr(loc_wr), .loc_wdata(loc_wdata), .loc_rd(loc_rd), .loc_rdata(loc_rdata),
        .full(full), .empty(empty), .xfer_pulse(xfer_pulse), .tc(tc)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] q[$];
    int            ph = P_WAIT;
    bit            m_eop = 0, m_tc = 0, m_pulse = 0;
    logic [DW-1:0] m_wlatch = '0;
    int            m_s;
    bit            m_rdy, m_bpush, m_bpop, m_fin, m_stb_low, m_push, m_pop;

    initial forever begin
        @(posedge CLK or posedge RESET);
        if (RESET) begin
            q.delete();
            ph = P_WAIT; m_eop = 0; m_tc = 0; m_pulse = 0; m_wlatch = '0;
        end else begin
            m_s       = q.size();
            m_rdy     = dir ? (m_s < DEPTH) : (m_s > 0);
            m_stb_low = dir ? !bus.IOW_N : !bus.IOR_N;
            m_bpush = 0; m_bpop = 0; m_fin = 0; m_pulse = 0;
            case (ph)
                P_WAIT: if (en && !m_tc && m_rdy) ph = P_REQ;
                P_REQ: begin
                    if (!bus.DACK_N) ph = P_GRANT;
                    else if (!en || !m_rdy) ph = P_WAIT;
                end
                P_GRANT: begin
                    if (!bus.EOP_N) m_eop = 1;
                    if (bus.DACK_N) m_fin = 1;
                    else if (m_stb_low) begin
                        if (dir) m_wlatch = bus.db_in;
                        ph = P_STROBE;
                    end
                end
                P_STROBE: begin
                    if (!bus.EOP_N) m_eop = 1;
                    if (!m_stb_low) begin
                        m_pulse = 1;
                        if (dir) m_bpush = 1; else m_bpop = 1;
                        m_fin = 1;
                    end else if (dir) m_wlatch = bus.db_in;
                end
                P_HALT: if (tc_clr) begin ph = P_WAIT; m_tc = 0; end
                default: ph = P_WAIT;
            endcase
            if (m_fin) begin
                if (m_eop) begin ph = P_HALT; m_tc = 1; end
                else ph = P_WAIT;
                m_eop = 0;
            end
            m_pop  = (m_s > 0) && (m_bpop || loc_rd);
            m_push = (m_s < DEPTH) && (m_bpush || loc_wr);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(m_bpush ? m_wlatch : loc_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit exp_oe;
    initial forever begin
        @(negedge CLK);
        exp_oe = (ph == P_STROBE) && !dir && !bus.IOR_N && !bus.DACK_N;
        chk("dreq", 32'(bus.DREQ), 32'(ph == P_REQ));
        chk("db_oe", 32'(bus.db_oe), 32'(exp_oe));
        if (!exp_oe) chk("db_out_idle", 32'(bus.db_out), 0);
        else if (q.size() > 0) chk("db_out", 32'(bus.db_out), 32'(q[0]));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("loc_rdata", 32'(loc_rdata), (q.size() > 0) ? 32'(q[0]) : 0);
        chk("tc", 32'(tc), 32'(m_tc));
        chk("xfer_pulse", 32'(xfer_pulse), 32'(m_pulse));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_loc) begin
            loc_wr    = !dir && ($urandom_range(0, 2) == 0);
            loc_rd    = dir && ($urandom_range(0, 2) == 0);
            loc_wdata = DW'($urandom);
        end
    endtask

    task automatic bus_cycle(input int dly, input int slen, input bit eop, input bit abort);
        int n = 0;
        while (!bus.DREQ && n < 40) begin tick(); n++; end
        if (!bus.DREQ) begin
            chk("dreq_wait_timeout", 32'(bus.DREQ), 1);
            return;
        end
        repeat (dly) tick();
        bus.DACK_N = 1'b0;
        tick();
        if (abort) begin
            bus.EOP_N = !eop;
            repeat (slen) tick();
            bus.DACK_N = 1'b1;
            tick();
            bus.EOP_N = 1'b1;
            return;
        end
        if (dir) bus.IOW_N = 1'b0; else bus.IOR_N = 1'b0;
        bus.EOP_N = !eop;
        for (int i = 0; i < slen; i++) begin
            bus.db_in = DW'($urandom);
            tick();
        end
        bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.DACK_N = 1'b1; bus.db_in = '0;
        tick();
        bus.EOP_N = 1'b1;
    endtask

    task automatic push_local(input logic [DW-1:0] d);
        loc_wdata = d; loc_wr = 1'b1;
        tick();
        loc_wr = 1'b0;
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.DACK_N = 1'b1; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.EOP_N = 1'b1; bus.db_in = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dreq", 32'(bus.DREQ), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdata", 32'(loc_rdata), 0);
        chk("rst_oe", 32'(bus.db_oe), 0);
        RESET = 1'b0;
        tick();

        // device-to-memory single beat
        push_local(8'hA5);
        en = 1'b1;
        tick();
        chk("d2m_dreq", 32'(bus.DREQ), 1);
        bus.DACK_N = 1'b0;
        tick();
        chk("d2m_dreq_ack", 32'(bus.DREQ), 0);
        bus.IOR_N = 1'b0;
        tick();
        chk("d2m_oe1", 32'(bus.db_oe), 1);
        chk("d2m_out1", 32'(bus.db_out), 32'hA5);
        tick();
        chk("d2m_out2", 32'(bus.db_out), 32'hA5);
        chk("d2m_nopulse", 32'(xfer_pulse), 0);
        bus.IOR_N = 1'b1; bus.DACK_N = 1'b1; en = 1'b0;
        tick();
        chk("d2m_pulse", 32'(xfer_pulse), 1);
        chk("d2m_empty", 32'(empty), 1);
        tick();
        chk("d2m_pulse_once", 32'(xfer_pulse), 0);

        // memory-to-device single beat, then minimum re-request spacing
        dir = 1'b1; en = 1'b1;
        tick();
        chk("m2d_dreq", 32'(bus.DREQ), 1);
        bus.DACK_N = 1'b0;
        tick();
        bus.IOW_N = 1'b0; bus.db_in = 8'h3C;
        tick();
        bus.IOW_N = 1'b1; bus.DACK_N = 1'b1; bus.db_in = '0;
        tick();
        chk("m2d_rdata", 32'(loc_rdata), 32'h3C);
        chk("m2d_pulse", 32'(xfer_pulse), 1);
        chk("m2d_dreq_gap", 32'(bus.DREQ), 0);
        tick();
        chk("m2d_dreq_4cyc", 32'(bus.DREQ), 1);

        // fill to full over the bus, then one local pop re-opens requests
        for (int i = 0; i < DEPTH - 1; i++) bus_cycle(0, 1, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fill_dreq_low", 32'(bus.DREQ), 0);
        end
        chk("fill_head", 32'(loc_rdata), 32'h3C);
        loc_rd = 1'b1;
        tick();
        loc_rd = 1'b0;
        chk("pop_not_full", 32'(full), 0);
        tick();
        chk("pop_dreq", 32'(bus.DREQ), 1);
        en = 1'b0;
        loc_rd = 1'b1;
        repeat (DEPTH) tick();
        loc_rd = 1'b0;
        tick();
        chk("drain_empty", 32'(empty), 1);

        // end-of-process on the third beat
        dir = 1'b0;
        for (int k = 0; k < 5; k++) push_local(DW'(8'h10 + k));
        en = 1'b1;
        bus_cycle(1, 2, 1'b0, 1'b0);
        bus_cycle(0, 1, 1'b0, 1'b0);
        bus_cycle(0, 2, 1'b1, 1'b0);
        chk("eop_tc", 32'(tc), 1);
        chk("eop_pending", 32'(empty), 0);
        for (int i = 0; i < 3; i++) begin
            chk("eop_dreq_held", 32'(bus.DREQ), 0);
            tick();
        end
        tc_clr = 1'b1;
        tick();
        tc_clr = 1'b0;
        chk("tcclr_tc", 32'(tc), 0);
        tick();
        chk("tcclr_dreq", 32'(bus.DREQ), 1);
        bus_cycle(0, 1, 1'b0, 1'b0);
        bus_cycle(0, 1, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        chk("eop_drained", 32'(empty), 1);

        // acknowledge/strobe while idle is ignored; acknowledge abort changes nothing
        push_local(8'h77);
        bus.DACK_N = 1'b0; bus.IOR_N = 1'b0;
        tick(); tick();
        bus.DACK_N = 1'b1; bus.IOR_N = 1'b1;
        tick();
        chk("idle_dack_ignored", 32'(loc_rdata), 32'h77);
        en = 1'b1;
        bus_cycle(0, 2, 1'b0, 1'b1);
        chk("abort_nopulse", 32'(xfer_pulse), 0);
        chk("abort_count", 32'(loc_rdata), 32'h77);
        chk("abort_not_empty", 32'(empty), 0);
        en = 1'b0;
        tick(); tick();

        // reset in the middle of a read beat
        en = 1'b1;
        tick();
        chk("rx_dreq", 32'(bus.DREQ), 1);
        bus.DACK_N = 1'b0;
        tick();
        bus.IOR_N = 1'b0;
        tick();
        chk("rx_oe", 32'(bus.db_oe), 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("rx_rst_oe", 32'(bus.db_oe), 0);
        chk("rx_rst_out", 32'(bus.db_out), 0);
        chk("rx_rst_empty", 32'(empty), 1);
        chk("rx_rst_dreq", 32'(bus.DREQ), 0);
        bus.IOR_N = 1'b1; bus.DACK_N = 1'b1; en = 1'b0;
        tick();
        RESET = 1'b0;
        tick();

        // randomized controller with concurrent local traffic
        rand_loc = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (i % 25 == 0) begin
                en = 1'b0;
                tick(); tick();
                dir = 1'($urandom_range(0, 1));
                en = 1'b1;
            end
            if (!dir && q.size() == 0) begin
                rand_loc = 1'b0; loc_rd = 1'b0;
                push_local(DW'($urandom));
                rand_loc = 1'b1;
            end else if (dir && q.size() == DEPTH) begin
                rand_loc = 1'b0; loc_wr = 1'b0; loc_rd = 1'b1;
                tick();
                loc_rd = 1'b0;
                rand_loc = 1'b1;
            end
            bus_cycle($urandom_range(0, 2), $urandom_range(1, 3),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if (m_tc) begin
                repeat ($urandom_range(1, 3)) tick();
                tc_clr = 1'b1;
                tick();
                tc_clr = 1'b0;
            end
        end
        rand_loc = 1'b0;
        loc_wr = 1'b0; loc_rd = 1'b0; en = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
